// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush controller: stage indices,
// stall masks and the MDU sequencer state type.
package pipe_ctrl_pkg;

  localparam int NUM_STAGES = 6;

  localparam int STG_PC  = 0;
  localparam int STG_IF  = 1;
  localparam int STG_ID  = 2;
  localparam int STG_EX  = 3;
  localparam int STG_MEM = 4;
  localparam int STG_WB  = 5;

  localparam logic STOP     = 1'b1;
  localparam logic NOT_STOP = 1'b0;

  typedef logic [NUM_STAGES-1:0] stall_vec_t;

  // A request from stage k holds stage k and everything upstream of it.
  localparam stall_vec_t STALL_NONE     = 6'b000000;
  localparam stall_vec_t STALL_MASK_IF  = 6'b000011;
  localparam stall_vec_t STALL_MASK_ID  = 6'b000111;
  localparam stall_vec_t STALL_MASK_EX  = 6'b001111;
  localparam stall_vec_t STALL_MASK_MEM = 6'b011111;

  typedef enum logic [1:0] {
    MDU_IDLE   = 2'd0,
    MDU_BUSY_S = 2'd1,
    MDU_DONE_S = 2'd2
  } mdu_state_t;

endpackage

// File: rtl/pipe_stall_ctrl_mdu_seq.sv
// Multi-cycle MULT/DIV sequencer: holds EX for the op's fixed latency,
// freezes while MEM is stalled, and pulses done when the result is ready.
module mdu_seq
  import pipe_ctrl_pkg::*;
#(
  parameter int DIV_CYCLES = 32,
  parameter int MUL_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic is_div,
  input  logic abort,
  input  logic mem_stall,
  output logic hold,
  output logic busy,
  output logic done
);

  localparam int CNT_W = $clog2(DIV_CYCLES + 1);
  // The start cycle and the final BUSY cycle are not counted down.
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 2);
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 2);

  mdu_state_t       state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= MDU_IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    hold       = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_reg)
      MDU_IDLE: begin
        if (start && !abort) begin
          state_next = MDU_BUSY_S;
          cnt_next   = is_div ? DIV_LOAD : MUL_LOAD;
          hold       = 1'b1;
        end
      end
      MDU_BUSY_S: begin
        hold = 1'b1;
        busy = 1'b1;
        if (!mem_stall) begin
          if (cnt_reg == '0) begin
            state_next = MDU_DONE_S;
          end else begin
            cnt_next = cnt_reg - 1'b1;
          end
        end
      end
      MDU_DONE_S: begin
        done = !abort;
        if (!mem_stall) begin
          state_next = MDU_IDLE;
        end
      end
      default: begin
        state_next = MDU_IDLE;
        cnt_next   = '0;
      end
    endcase
    // An exception kills the op in flight; its result is never delivered.
    if (abort) begin
      state_next = MDU_IDLE;
      cnt_next   = '0;
    end
  end

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Central stall/flush controller for the 6-stage pipeline: merges per-stage
// stall requests and the MDU hold into one STALL vector, and drives flush/redirect.
module pipe_stall_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int DIV_CYCLES = 32,
  parameter int MUL_CYCLES = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        STALLREQ_IF,
  input  logic        STALLREQ_ID,
  input  logic        STALLREQ_EX,
  input  logic        STALLREQ_MEM,
  input  logic        MDU_START,
  input  logic        MDU_IS_DIV,
  input  logic        EXC_VALID,
  input  logic [31:0] EXC_PC,
  output logic [5:0]  STALL,
  output logic        FLUSH,
  output logic [31:0] NEW_PC,
  output logic        MDU_BUSY,
  output logic        MDU_DONE
);

  logic       mdu_hold;
  logic       mdu_busy;
  logic       mdu_done;
  stall_vec_t stall_req;

  mdu_seq #(
    .DIV_CYCLES(DIV_CYCLES),
    .MUL_CYCLES(MUL_CYCLES)
  ) u_mdu_seq (
    .clk       (CLK),
    .rst       (RST),
    .start     (MDU_START),
    .is_div    (MDU_IS_DIV),
    .abort     (EXC_VALID),
    .mem_stall (STALLREQ_MEM),
    .hold      (mdu_hold),
    .busy      (mdu_busy),
    .done      (mdu_done)
  );

  // Deepest requester wins; its mask already covers every upstream stage.
  always_comb begin
    stall_req = STALL_NONE;
    if (STALLREQ_MEM) begin
      stall_req = STALL_MASK_MEM;
    end else if (STALLREQ_EX || mdu_hold) begin
      stall_req = STALL_MASK_EX;
    end else if (STALLREQ_ID) begin
      stall_req = STALL_MASK_ID;
    end else if (STALLREQ_IF) begin
      stall_req = STALL_MASK_IF;
    end
  end

  // Reset forces every output to its idle value even while requests are live;
  // a flush clears the pipe so nothing needs to be held in that cycle.
  always_comb begin
    STALL    = STALL_NONE;
    FLUSH    = 1'b0;
    NEW_PC   = '0;
    MDU_BUSY = 1'b0;
    MDU_DONE = 1'b0;
    if (!RST) begin
      FLUSH    = EXC_VALID;
      NEW_PC   = EXC_VALID ? EXC_PC : 32'h0;
      STALL    = EXC_VALID ? STALL_NONE : stall_req;
      MDU_BUSY = mdu_busy;
      MDU_DONE = mdu_done;
    end
  end

endmodule
